// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the serialiser state encoding, register offsets relative to
// BASE_ADDR, STATUS bit positions and the STATUS register layout.
// Optional feature macro: MMIO_UART_PARITY_EN (even-parity 8E1 frames).
`timescale 1ns/1ps
package mmio_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } uart_state_e;

  localparam int unsigned OFS_TXDATA = 0;
  localparam int unsigned OFS_STATUS = 1;

  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_EMPTY = 1;
  localparam int unsigned STAT_FULL  = 2;
  localparam int unsigned STAT_OVF   = 3;
  localparam int unsigned STAT_PAR   = 4;

  localparam int unsigned CNT_W = 16;

  // STATUS register image, busy in bit 0
  typedef struct packed {
    logic [10:0] rsvd;
    logic        par;
    logic        ovf;
    logic        full;
    logic        empty;
    logic        busy;
  } status_t;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// uart_tx_fifo: byte queue between the bus write port and the serialiser.
// Ports: clk_i, rst_ni (synchronous, active-low), push_i/din_i write side,
// pop_i/dout_o read side (dout_o shows the head), full_o/empty_o flags.
// Pointers carry one extra wrap bit; a push while full is accepted only
// when a pop frees a slot in the same cycle.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full_c, empty_c, push_ok_c, pop_ok_c;

  // Flags from pointer compare; MSB differs only when wrapped once
  always_comb begin
    empty_c   = (wr_q == rd_q);
    full_c    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop_ok_c  = pop_i && !empty_c;
    push_ok_c = push_i && (!full_c || pop_ok_c);
    wr_d      = wr_q + PW'(push_ok_c);
    rd_d      = rd_q + PW'(pop_ok_c);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset; only pointer-qualified entries are read
  always_ff @(posedge clk_i) begin
    if (push_ok_c) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign full_o  = full_c;
  assign empty_o = empty_c;

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter on the processor data bus.
// Stores to BASE_ADDR queue a byte; a store to BASE_ADDR+1 with DOUT[3]=1
// clears the sticky overflow flag. STATUS at BASE_ADDR+1 is returned
// through a registered read port (1-cycle latency).
// Ports: clk_50MHz, reset_n (synchronous, active-low), ADDR[7:0],
// DOUT[15:0], W in; rd_data[15:0], rd_hit, txd (idles high), tx_busy out.
// Optional feature macro: MMIO_UART_PARITY_EN adds an even-parity bit
// (8E1) and sets STATUS bit 4; otherwise frames are 8N1.
`timescale 1ns/1ps
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR    = 8'hF0,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk_50MHz,
  input  logic        reset_n,
  input  logic [7:0]  ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] rd_data,
  output logic        rd_hit,
  output logic        txd,
  output logic        tx_busy
);

  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        data_q, data_d;
  logic              ovf_q, ovf_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic [15:0]       rd_data_q, rd_data_d;
  logic              rd_hit_q, rd_hit_d;

  logic              hit_tx_c, hit_st_c, push_c, pop_c, bit_done_c;
  logic              fifo_full, fifo_empty;
  logic [7:0]        fifo_dout;
  status_t           status_c;
  logic              dout_unused;

  assign dout_unused = ^DOUT[15:8];

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_50MHz),
    .rst_ni  (reset_n),
    .push_i  (push_c),
    .din_i   (DOUT[7:0]),
    .pop_i   (pop_c),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Bus decode, overflow flag and registered STATUS read
  always_comb begin
    hit_tx_c = (ADDR == BASE_ADDR + 8'(OFS_TXDATA));
    hit_st_c = (ADDR == BASE_ADDR + 8'(OFS_STATUS));
    push_c   = W && hit_tx_c;

    status_c       = '0;
    status_c.busy  = busy_q;
    status_c.empty = fifo_empty;
    status_c.full  = fifo_full;
    status_c.ovf   = ovf_q;
`ifdef MMIO_UART_PARITY_EN
    status_c.par   = 1'b1;
`else
    status_c.par   = 1'b0;
`endif

    ovf_d = ovf_q;
    // A full FIFO still takes the byte when the serialiser pops this cycle
    if (push_c && fifo_full && !pop_c) ovf_d = 1'b1;
    if (W && hit_st_c && DOUT[STAT_OVF]) ovf_d = 1'b0;

    rd_data_d = hit_st_c ? status_c : 16'h0000;
    rd_hit_d  = hit_tx_c || hit_st_c;
  end

  assign bit_done_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // State register (with baud counter, data and output registers)
  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      rd_data_q <= '0;
      rd_hit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_hit_q  <= rd_hit_d;
    end
  end

  // Next-state logic; every bit holds for CLKS_PER_BIT cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pop_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          data_d  = fifo_dout;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_done_c) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_done_c) begin
          cnt_d = '0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef MMIO_UART_PARITY_EN
      ST_PARITY: begin
        if (bit_done_c) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (bit_done_c) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic, registered one cycle behind the state
  always_comb begin
    txd_d  = 1'b1;
    busy_d = 1'b0;
    unique case (state_q)
      ST_START: begin
        txd_d  = 1'b0;
        busy_d = 1'b1;
      end
      ST_DATA: begin
        txd_d  = data_q[bit_q];
        busy_d = 1'b1;
      end
`ifdef MMIO_UART_PARITY_EN
      ST_PARITY: begin
        txd_d  = ^data_q;
        busy_d = 1'b1;
      end
`endif
      ST_STOP: begin
        txd_d  = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign rd_data = rd_data_q;
  assign rd_hit  = rd_hit_q;
  assign txd     = txd_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A queue-based frame model predicts txd/tx_busy/rd_data/rd_hit each cycle;
// directed sequences add literal expectations for latency, frame bits,
// STATUS values and reset behaviour.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam int CPB = 4;
  localparam int DEP = 4;
`ifdef MMIO_UART_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int NB  = 11;
`else
  localparam bit PAR = 1'b0;
  localparam int NB  = 10;
`endif
  localparam int FRAME = NB * CPB;
  localparam logic [15:0] PARB = PAR ? 16'h0010 : 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  ADDR = 8'h00;
  logic [15:0] DOUT = 16'h0000;
  logic        W = 1'b0;
  logic [15:0] rd_data;
  logic        rd_hit, txd, tx_busy;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_uart_tx #(
    .BASE_ADDR    (8'hF0),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEP)
  ) dut (
    .clk_50MHz (clk),
    .reset_n   (reset_n),
    .ADDR      (ADDR),
    .DOUT      (DOUT),
    .W         (W),
    .rd_data   (rd_data),
    .rd_hit    (rd_hit),
    .txd       (txd),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [7:0]  q[$];
  int          pos = -1;          // cycles since frame start, -1 when line idle
  logic [7:0]  cur = 8'h00;
  logic        ovf_m = 1'b0;
  logic        exp_txd = 1'b1, exp_busy = 1'b0, exp_hit = 1'b0;
  logic [15:0] exp_rd = 16'h0;
  logic [15:0] m_stat;
  bit          model_ok = 1'b0;
  bit          m_pop;
  int          m_sz;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NB == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      q.delete();
      pos = -1; ovf_m = 1'b0;
      exp_txd = 1'b1; exp_busy = 1'b0; exp_rd = 16'h0; exp_hit = 1'b0;
      model_ok = 1'b1;
    end else begin
      m_sz   = q.size();
      m_stat = PARB | {12'h0, ovf_m, (m_sz == DEP), (m_sz == 0), exp_busy};
      exp_rd  = (ADDR == 8'hF1) ? m_stat : 16'h0;
      exp_hit = (ADDR == 8'hF0) || (ADDR == 8'hF1);
      exp_txd  = (pos < 0) ? 1'b1 : frame_bit(cur, pos / CPB);
      exp_busy = (pos >= 0);
      m_pop = (pos < 0) && (m_sz > 0);
      if (pos >= 0) begin
        pos++;
        if (pos == FRAME) pos = -1;
      end
      if (m_pop) begin
        cur = q.pop_front();
        pos = 0;
      end
      if (W && ADDR == 8'hF0) begin
        if (q.size() < DEP) q.push_back(DOUT[7:0]);
        else ovf_m = 1'b1;
      end
      if (W && ADDR == 8'hF1 && DOUT[3]) ovf_m = 1'b0;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_txd", 16'(txd), 16'(exp_txd));
      chk("model_busy", 16'(tx_busy), 16'(exp_busy));
      chk("model_rd_data", rd_data, exp_rd);
      chk("model_rd_hit", 16'(rd_hit), 16'(exp_hit));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus(input logic [7:0] a, input logic [15:0] d, input logic w);
    @(negedge clk);
    ADDR = a; DOUT = d; W = w;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(8'h00, 16'h0000, 1'b0);
  endtask

  // Called right after a TX_DATA write; lat counts edges after the write edge
  task automatic capture(output int lat, output int len, output logic [10:0] bits);
    lat = -1; len = 0; bits = '0;
    for (int i = 0; i < 100; i++) begin
      idle(1);
      lat++;
      if (tx_busy === 1'b1) break;
    end
    while (tx_busy === 1'b1 && len < 200) begin
      if (len % CPB == 1 && len / CPB < 11) bits[len / CPB] = txd;
      len++;
      idle(1);
    end
  endtask

  int          lat, len, lows;
  logic [10:0] bits;

  initial begin
    // 1. reset, single byte 0x55
    idle(2);
    reset_n = 1'b1;
    idle(1);
    chk("reset_txd", 16'(txd), 16'h1);
    chk("reset_busy", 16'(tx_busy), 16'h0);
    chk("reset_rd_data", rd_data, 16'h0);
    bus(8'hF0, 16'h0055, 1'b1);
    capture(lat, len, bits);
    chk("t1_latency", 16'(lat), 16'd2);
    chk("t1_frame_len", 16'(len), 16'(FRAME));
    chk("t1_bits", 16'(bits), PAR ? 16'h04AA : 16'h02AA);
    idle(4);

    // 2. six back-to-back writes, one dropped
    for (int i = 0; i < 6; i++) bus(8'hF0, 16'(8'h10 + i), 1'b1);
    bus(8'hF1, 16'h0000, 1'b0);
    idle(1);
    chk("t2_status_ovf", rd_data, 16'h000D | PARB);
    bus(8'hF1, 16'h0008, 1'b1);
    bus(8'hF1, 16'h0000, 1'b0);
    idle(1);
    chk("t2_status_clr", rd_data, 16'h0005 | PARB);
    idle(300);

    // 3. reads while idle and empty
    bus(8'hF1, 16'h0000, 1'b0);
    bus(8'h10, 16'h0000, 1'b0);
    chk("t3_status", rd_data, 16'h0002 | PARB);
    chk("t3_hit", 16'(rd_hit), 16'h1);
    bus(8'hF0, 16'h0000, 1'b0);
    chk("t3_miss_data", rd_data, 16'h0);
    chk("t3_miss_hit", 16'(rd_hit), 16'h0);
    idle(1);
    chk("t3_txdata_rd", rd_data, 16'h0);
    chk("t3_txdata_hit", 16'(rd_hit), 16'h1);

    // 4. push into a full FIFO on the cycle the serialiser pops
    for (int i = 0; i < 5; i++) bus(8'hF0, 16'(8'hC0 + i), 1'b1);
    idle(FRAME - 3);
    bus(8'hF0, 16'h00C5, 1'b1);
    bus(8'hF1, 16'h0000, 1'b0);
    idle(1);
    chk("t4_status", rd_data, 16'h0004 | PARB);
    idle(300);

    // 5. reset in the middle of 0xA3's data bits
    bus(8'hF0, 16'h00A3, 1'b1);
    idle(8);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    chk("t5_txd", 16'(txd), 16'h1);
    chk("t5_busy", 16'(tx_busy), 16'h0);
    bus(8'hF1, 16'h0000, 1'b0);
    idle(1);
    chk("t5_status", rd_data, 16'h0002 | PARB);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      idle(1);
      if (txd !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    chk("t5_quiet_line", 16'(lows), 16'h0);

    // 6. byte 0x07: parity bit set when enabled, frame length per build
    bus(8'hF0, 16'h0007, 1'b1);
    capture(lat, len, bits);
    chk("t6_frame_len", 16'(len), PAR ? 16'd44 : 16'd40);
    chk("t6_bits", 16'(bits), PAR ? 16'h060E : 16'h020E);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
